// File: rtl/multi_master_cmd_processor.sv
// multi_master_cmd_processor
//   Button/switch command front end for the bus test rig. A config FSM
//   stages slave/address/data/burst and commits them to one master's
//   command registers. In run mode, per-master trigger buttons raise
//   level read/write requests.
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   btn_up/down/enter      config buttons (edge detected internally)
//   switch_array           value entry switches (ADDR_LEN bits)
//   mode_switch            0 = config mode, 1 = run mode
//   rw_switch, trig        per-master direction (1 = read) and issue button
//   cmd_done               per-master completion pulse
//   read, write            per-master request levels
//   slave_bus/address_bus/data_bus/burst_bus  committed fields, master m at slice m
//   config_state           current FSM state (debug visibility)
//   disp_val               {1'b0, state, 12-bit field}; 0 in run mode
//
// Request handshake: a request is raised by a trig edge while the master
// is idle, held as a level until cmd_done[m] is seen, and dropped the
// following cycle. A trig seen together with cmd_done, or while the
// request is active, is ignored.
//
// Optional feature: define CMD_PROC_AUTOINC_EN to advance address[m] by
// burst[m] on every cmd_done[m].
module multi_master_cmd_processor #(
  parameter int MASTER_NUM = 2,
  parameter int MASTER_LEN = 1,
  parameter int SLAVE_NUM  = 3,
  parameter int SLAVE_LEN  = 2,
  parameter int ADDR_LEN   = 12,
  parameter int DATA_LEN   = 8,
  parameter int BURST_LEN  = 12
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              btn_up,
  input  logic                              btn_down,
  input  logic                              btn_enter,
  input  logic [ADDR_LEN-1:0]               switch_array,
  input  logic                              mode_switch,
  input  logic [MASTER_NUM-1:0]             rw_switch,
  input  logic [MASTER_NUM-1:0]             trig,
  input  logic [MASTER_NUM-1:0]             cmd_done,
  output logic [MASTER_NUM-1:0]             read,
  output logic [MASTER_NUM-1:0]             write,
  output logic [MASTER_NUM*SLAVE_LEN-1:0]   slave_bus,
  output logic [MASTER_NUM*(ADDR_LEN+1)-1:0] address_bus,
  output logic [MASTER_NUM*DATA_LEN-1:0]    data_bus,
  output logic [MASTER_NUM*(BURST_LEN+1)-1:0] burst_bus,
  output logic [2:0]                        config_state,
  output logic [15:0]                       disp_val
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_SEL_MASTER = 3'd1;
  localparam logic [2:0] S_SEL_SLAVE  = 3'd2;
  localparam logic [2:0] S_SEL_ADDR   = 3'd3;
  localparam logic [2:0] S_SEL_DATA   = 3'd4;
  localparam logic [2:0] S_SEL_BURST  = 3'd5;
  localparam logic [2:0] S_CONFIRM    = 3'd6;

  localparam int                    BURST_MAX   = (2**BURST_LEN) - 1;
  localparam logic [BURST_LEN:0]    BURST_CAP   = (BURST_LEN+1)'(BURST_MAX);
  localparam logic [BURST_LEN:0]    BURST_ONE   = (BURST_LEN+1)'(1);
  localparam logic [MASTER_LEN-1:0] MASTER_LAST = MASTER_LEN'(MASTER_NUM - 1);
  localparam logic [SLAVE_LEN-1:0]  SLAVE_MAX   = SLAVE_LEN'(SLAVE_NUM);
  localparam logic [SLAVE_LEN-1:0]  SLAVE_ONE   = SLAVE_LEN'(1);

`ifdef CMD_PROC_AUTOINC_EN
  localparam bit AUTOINC_EN = 1'b1;
`else
  localparam bit AUTOINC_EN = 1'b0;
`endif

  // Edge detect and staging registers
  logic [2:0]            r_btn_q;  // {enter, up, down}
  logic [2:0]            r_state;
  logic [MASTER_LEN-1:0] r_st_master;
  logic [SLAVE_LEN-1:0]  r_st_slave;
  logic [ADDR_LEN:0]     r_st_addr;
  logic [DATA_LEN-1:0]   r_st_data;
  logic [BURST_LEN:0]    r_st_burst;

  // Committed per-master command registers
  logic [SLAVE_LEN-1:0]  r_slave [MASTER_NUM];
  logic [ADDR_LEN:0]     r_addr  [MASTER_NUM];
  logic [DATA_LEN-1:0]   r_data  [MASTER_NUM];
  logic [BURST_LEN:0]    r_burst [MASTER_NUM];

  // Request path
  logic [MASTER_NUM-1:0] r_trig_q;
  logic [MASTER_NUM-1:0] r_take;   // accepted trig, one stage before the request level
  logic [MASTER_NUM-1:0] r_req;
  logic [MASTER_NUM-1:0] r_dir;    // 1 = read, sampled when the trig is accepted

  logic [2:0]            w_btn_edge;
  logic                  w_enter, w_up, w_down, w_any;
  logic [BURST_LEN:0]    w_burst_val;
  logic                  w_sel_busy, w_commit;
  logic [MASTER_NUM-1:0] w_trig_edge, w_take;
  logic [11:0]           w_field;

  // Enter beats up, up beats down when edges coincide
  assign w_btn_edge = {btn_enter, btn_up, btn_down} & ~r_btn_q;
  assign w_enter    = w_btn_edge[2];
  assign w_up       = w_btn_edge[1] & ~w_btn_edge[2];
  assign w_down     = w_btn_edge[0] & ~w_btn_edge[1] & ~w_btn_edge[2];
  assign w_any      = |w_btn_edge;

  // Burst entry: 0 means 1, otherwise clamp to the largest encodable burst
  always_comb begin
    w_burst_val = (BURST_LEN+1)'(switch_array);
    if (switch_array == '0)                  w_burst_val = BURST_ONE;
    else if (int'(switch_array) > BURST_MAX) w_burst_val = BURST_CAP;
  end

  // A master with a live request cannot have its command changed under it
  assign w_sel_busy = r_req[r_st_master];
  assign w_commit   = ~mode_switch & (r_state == S_CONFIRM) & w_enter & ~w_sel_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_q     <= '0;
      r_state     <= S_IDLE;
      r_st_master <= '0;
      r_st_slave  <= '0;
      r_st_addr   <= '0;
      r_st_data   <= '0;
      r_st_burst  <= '0;
    end else begin
      r_btn_q <= {btn_enter, btn_up, btn_down};
      if (mode_switch) begin
        r_state     <= S_IDLE;
        r_st_master <= '0;
        r_st_slave  <= '0;
        r_st_addr   <= '0;
        r_st_data   <= '0;
        r_st_burst  <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (w_any) begin
            r_state     <= S_SEL_MASTER;
            r_st_master <= '0;
            r_st_slave  <= SLAVE_ONE;
            r_st_addr   <= '0;
            r_st_data   <= '0;
            r_st_burst  <= BURST_ONE;
          end
          S_SEL_MASTER: begin
            if (w_enter)     r_state     <= S_SEL_SLAVE;
            else if (w_up)   r_st_master <= (r_st_master == MASTER_LAST) ? '0 : r_st_master + 1'b1;
            else if (w_down) r_st_master <= (r_st_master == '0) ? MASTER_LAST : r_st_master - 1'b1;
          end
          S_SEL_SLAVE: begin
            if (w_enter)     r_state    <= S_SEL_ADDR;
            else if (w_up)   r_st_slave <= (r_st_slave >= SLAVE_MAX) ? SLAVE_ONE : r_st_slave + 1'b1;
            else if (w_down) r_st_slave <= (r_st_slave <= SLAVE_ONE) ? SLAVE_MAX : r_st_slave - 1'b1;
          end
          S_SEL_ADDR: if (w_any) begin
            r_st_addr <= {1'b0, switch_array};
            r_state   <= S_SEL_DATA;
          end
          S_SEL_DATA: if (w_any) begin
            r_st_data <= switch_array[DATA_LEN-1:0];
            r_state   <= S_SEL_BURST;
          end
          S_SEL_BURST: if (w_any) begin
            r_st_burst <= w_burst_val;
            r_state    <= S_CONFIRM;
          end
          S_CONFIRM: begin
            // A blocked enter leaves the FSM waiting here for the master to go idle
            if (w_enter) begin
              if (!w_sel_busy) r_state <= S_IDLE;
            end else if (w_up || w_down) begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < MASTER_NUM; m++) begin
        r_slave[m] <= SLAVE_ONE;
        r_addr[m]  <= '0;
        r_data[m]  <= '0;
        r_burst[m] <= BURST_ONE;
      end
    end else begin
      for (int m = 0; m < MASTER_NUM; m++) begin
        if (w_commit && (r_st_master == MASTER_LEN'(m))) begin
          r_slave[m] <= r_st_slave;
          r_addr[m]  <= r_st_addr;
          r_data[m]  <= r_st_data;
          r_burst[m] <= r_st_burst;
        end else if (AUTOINC_EN && cmd_done[m]) begin
          // Top address bit is a flag and is not part of the increment
          r_addr[m][ADDR_LEN-1:0] <= r_addr[m][ADDR_LEN-1:0] + ADDR_LEN'(r_burst[m]);
        end
      end
    end
  end

  assign w_trig_edge = trig & ~r_trig_q;
  assign w_take      = w_trig_edge & ~r_req & ~cmd_done & {MASTER_NUM{mode_switch}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_trig_q <= '0;
      r_take   <= '0;
      r_req    <= '0;
      r_dir    <= '0;
    end else begin
      r_trig_q <= trig;
      r_take   <= w_take;
      for (int m = 0; m < MASTER_NUM; m++) begin
        if (w_take[m])        r_dir[m] <= rw_switch[m];
        if (r_take[m])        r_req[m] <= 1'b1;
        else if (cmd_done[m]) r_req[m] <= 1'b0;
      end
    end
  end

  assign read  = r_req & r_dir;
  assign write = r_req & ~r_dir;

  genvar g;
  for (g = 0; g < MASTER_NUM; g++) begin : g_out
    assign slave_bus[g*SLAVE_LEN +: SLAVE_LEN]           = r_slave[g];
    assign address_bus[g*(ADDR_LEN+1) +: (ADDR_LEN+1)]   = r_addr[g];
    assign data_bus[g*DATA_LEN +: DATA_LEN]              = r_data[g];
    assign burst_bus[g*(BURST_LEN+1) +: (BURST_LEN+1)]   = r_burst[g];
  end

  assign config_state = r_state;

  // Staged value in the selection states, live switches in the entry states
  always_comb begin
    w_field = '0;
    case (r_state)
      S_SEL_MASTER:                        w_field = 12'(r_st_master);
      S_SEL_SLAVE:                         w_field = 12'(r_st_slave);
      S_SEL_ADDR, S_SEL_DATA, S_SEL_BURST: w_field = 12'(switch_array);
      default:                             w_field = '0;
    endcase
  end

  assign disp_val = mode_switch ? 16'h0000 : {1'b0, r_state, w_field};

endmodule

// File: tb/tb_multi_master_cmd_processor.sv
module tb_multi_master_cmd_processor;

  logic        clk;
  logic        reset;
  logic        btn_up, btn_down, btn_enter;
  logic [11:0] switch_array;
  logic        mode_switch;
  logic [1:0]  rw_switch, trig, cmd_done;
  logic [1:0]  read, write;
  logic [3:0]  slave_bus;
  logic [25:0] address_bus;
  logic [15:0] data_bus;
  logic [25:0] burst_bus;
  logic [2:0]  config_state;
  logic [15:0] disp_val;

  // Second instance with a narrower burst field, same stimulus
  logic [1:0]  read8, write8;
  logic [3:0]  slave_bus8;
  logic [25:0] address_bus8;
  logic [15:0] data_bus8;
  logic [17:0] burst_bus8;
  logic [2:0]  config_state8;
  logic [15:0] disp_val8;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] B_ENT  = 3'b100;
  localparam logic [2:0] B_UP   = 3'b010;
  localparam logic [2:0] B_DOWN = 3'b001;

  multi_master_cmd_processor u_dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter),
    .switch_array(switch_array), .mode_switch(mode_switch), .rw_switch(rw_switch),
    .trig(trig), .cmd_done(cmd_done), .read(read), .write(write), .slave_bus(slave_bus),
    .address_bus(address_bus), .data_bus(data_bus), .burst_bus(burst_bus),
    .config_state(config_state), .disp_val(disp_val)
  );

  multi_master_cmd_processor #(.BURST_LEN(8)) u_dut8 (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter),
    .switch_array(switch_array), .mode_switch(mode_switch), .rw_switch(rw_switch),
    .trig(trig), .cmd_done(cmd_done), .read(read8), .write(write8), .slave_bus(slave_bus8),
    .address_bus(address_bus8), .data_bus(data_bus8), .burst_bus(burst_bus8),
    .config_state(config_state8), .disp_val(disp_val8)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // Driver tasks
  task automatic press(input logic [2:0] b);
    btn_enter = b[2]; btn_up = b[1]; btn_down = b[0];
    tick(1);
    btn_enter = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    tick(1);
  endtask

  // From IDLE, walk the FSM to CONFIRM with the given fields staged
  task automatic cfg(input int m, input int ups, input logic [11:0] a,
                     input logic [11:0] d, input logic [11:0] b);
    press(B_UP);
    repeat (m) press(B_UP);
    press(B_ENT);
    repeat (ups) press(B_UP);
    press(B_ENT);
    switch_array = a; press(B_ENT);
    switch_array = d; press(B_ENT);
    switch_array = b; press(B_ENT);
    switch_array = '0;
  endtask

  task automatic pulse_done(input logic [1:0] d);
    cmd_done = d;
    tick(1);
    cmd_done = '0;
  endtask

  initial begin
    reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_enter = 1'b1;
    switch_array = '0; mode_switch = 1'b0; rw_switch = '0; trig = '0; cmd_done = '0;
    tick(2);

    // Reset values, enter held through reset
    chk("rst_state",   32'(config_state), 32'd0);
    chk("rst_read",    32'(read),         32'd0);
    chk("rst_write",   32'(write),        32'd0);
    chk("rst_slave",   32'(slave_bus),    32'h5);
    chk("rst_addr",    32'(address_bus),  32'h0);
    chk("rst_data",    32'(data_bus),     32'h0);
    chk("rst_burst",   32'(burst_bus),    32'h2001);
    chk("rst_burst8",  32'(burst_bus8),   32'h201);
    chk("rst_disp",    32'(disp_val),     32'h0);

    reset = 1'b0;
    tick(1);
    chk("rel_edge_state", 32'(config_state), 32'd1);
    btn_enter = 1'b0;
    tick(1);
    chk("held_no_edge", 32'(disp_val), 32'h1000);

    // Master 1, slave up x3 wraps to 1, addr 0x2A5, data 0x3C, burst 0 -> 1
    press(B_UP);
    chk("master_up", 32'(disp_val), 32'h1001);
    press(B_ENT);
    chk("slave_start", 32'(disp_val), 32'h2001);
    press(B_UP);
    chk("slave_up1", 32'(disp_val), 32'h2002);
    press(B_UP);
    press(B_UP);
    chk("slave_wrap", 32'(disp_val), 32'h2001);
    press(B_ENT);
    switch_array = 12'h2A5;
    tick(1);
    chk("disp_live_addr", 32'(disp_val), 32'h32A5);
    press(B_ENT);
    switch_array = 12'h03C; press(B_ENT);
    switch_array = 12'h000; press(B_ENT);
    chk("confirm_disp", 32'(disp_val), 32'h6000);
    press(B_ENT);
    chk("commit1_state", 32'(config_state), 32'd0);
    chk("commit1_slave", 32'(slave_bus),    32'h5);
    chk("commit1_addr",  32'(address_bus),  32'h54A000);
    chk("commit1_data",  32'(data_bus),     32'h3C00);
    chk("commit1_burst", 32'(burst_bus),    32'h2001);

    // Master 0, up+down -> up wins, burst 0xFFF, enter+up -> enter wins
    press(B_UP);
    press(B_ENT);
    press(B_UP | B_DOWN);
    chk("prio_up_down", 32'(disp_val), 32'h2002);
    press(B_ENT);
    switch_array = 12'h123; press(B_ENT);
    switch_array = 12'h05A; press(B_ENT);
    switch_array = 12'hFFF; press(B_ENT);
    switch_array = 12'h000;
    press(B_ENT | B_UP);
    chk("prio_ent_state", 32'(config_state), 32'd0);
    chk("commit2_slave",  32'(slave_bus),    32'h6);
    chk("commit2_addr",   32'(address_bus),  32'h54A123);
    chk("commit2_data",   32'(data_bus),     32'h3C5A);
    chk("commit2_burst",  32'(burst_bus),    32'h2FFF);
    chk("commit2_burst8", 32'(burst_bus8),   32'h2FF);

    // Discard in CONFIRM with down
    cfg(1, 1, 12'h777, 12'h077, 12'h007);
    chk("cfg_confirm", 32'(config_state), 32'd6);
    press(B_DOWN);
    chk("discard_state", 32'(config_state), 32'd0);
    chk("discard_addr",  32'(address_bus),  32'h54A123);

    // Mode toggle mid-config
    press(B_UP);
    press(B_ENT);
    chk("mid_cfg_state", 32'(config_state), 32'd2);
    mode_switch = 1'b1;
    tick(1);
    chk("mode_idle",  32'(config_state), 32'd0);
    chk("mode_disp",  32'(disp_val),     32'h0);
    chk("mode_keep",  32'(data_bus),     32'h3C5A);
    press(B_UP);
    chk("run_btn_ignored", 32'(config_state), 32'd0);

    // Run mode: master 0 read
    rw_switch = 2'b01;
    trig = 2'b01;
    tick(1);
    chk("trig_lat1", 32'(read), 32'h0);
    tick(1);
    chk("trig_lat2_read",  32'(read),  32'h1);
    chk("trig_lat2_write", 32'(write), 32'h0);
    rw_switch = 2'b00;
    tick(1);
    chk("dir_held", 32'(read), 32'h1);
    trig = 2'b00;
    cmd_done = 2'b01;
    tick(1);
    cmd_done = 2'b00;
    chk("done_drop", 32'(read), 32'h0);

    // Master 1 write, then trig together with cmd_done
    trig = 2'b10;
    tick(1);
    trig = 2'b00;
    tick(1);
    chk("m1_write", 32'(write), 32'h2);
    trig = 2'b10;
    cmd_done = 2'b10;
    tick(1);
    cmd_done = 2'b00;
    chk("trig_done_drop", 32'(write), 32'h0);
    trig = 2'b00;
    tick(2);
    chk("no_retrig_w", 32'(write), 32'h0);
    chk("no_retrig_r", 32'(read),  32'h0);

    // Request held across a return to config; commit blocked while active
    rw_switch = 2'b01;
    trig = 2'b01;
    tick(1);
    trig = 2'b00;
    tick(1);
    chk("req2_read", 32'(read), 32'h1);
    mode_switch = 1'b0;
    trig = 2'b10;
    tick(1);
    trig = 2'b00;
    tick(1);
    chk("cfg_trig_ignored", 32'(write), 32'h0);
    cfg(0, 0, 12'h0F0, 12'h011, 12'h002);
    press(B_ENT);
    chk("blocked_state", 32'(config_state), 32'd6);
    chk("blocked_slave", 32'(slave_bus),    32'h6);
    chk("held_in_cfg",   32'(read),         32'h1);
    pulse_done(2'b01);
    chk("held_done", 32'(read), 32'h0);
    press(B_ENT);
    chk("unblocked_state", 32'(config_state),      32'd0);
    chk("commit3_addr0",   32'(address_bus[12:0]), 32'h0F0);
    chk("commit3_data",    32'(data_bus),          32'h3C11);
    chk("commit3_burst0",  32'(burst_bus[12:0]),   32'h2);
    chk("commit3_burst8",  32'(burst_bus8[8:0]),   32'h2);

    // Address auto-increment on cmd_done
    cfg(1, 0, 12'hFFE, 12'h077, 12'h004);
    press(B_ENT);
    chk("commit4_addr1", 32'(address_bus[25:13]), 32'hFFE);
    pulse_done(2'b10);
    tick(1);
`ifdef CMD_PROC_AUTOINC_EN
    chk("autoinc_addr1", 32'(address_bus[25:13]), 32'h002);
`else
    chk("autoinc_addr1", 32'(address_bus[25:13]), 32'hFFE);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
